// File: rtl/dbus_mem_responder_if.sv
// DBUS responder interface: core request/response signals plus the
// console TX byte stream, grouped so one bundle connects core and responder.
interface dbus_mem_responder_if;
    logic [31:0] iDbusAddr;
    logic        iDbusWe;
    logic [31:0] iDbusData;
    logic        iDbusRead;
    logic [3:0]  iDbusByteEn;
    logic [31:0] oDbusData;
    logic        oDbusWait;
    logic [7:0]  oTxData;
    logic        oTxValid;
    logic        iTxReady;

    // Requesting side: the core plus the console consumer.
    modport master (
        output iDbusAddr, iDbusWe, iDbusData, iDbusRead, iDbusByteEn, iTxReady,
        input  oDbusData, oDbusWait, oTxData, oTxValid
    );

    // Responding side: memory and console register.
    modport slave (
        input  iDbusAddr, iDbusWe, iDbusData, iDbusRead, iDbusByteEn, iTxReady,
        output oDbusData, oDbusWait, oTxData, oTxValid
    );
endinterface

// File: rtl/dbus_mem_responder.sv
// DBUS responder: word-organised data RAM with size-coded lane writes,
// programmable wait states, and a memory-mapped console TX register
// backed by a small byte FIFO streamed out on a valid/ready port.
module dbus_mem_responder #(
    parameter int          ADDR_BITS    = 8,
    parameter int          WAIT_CYCLES  = 0,
    parameter logic [31:0] CONSOLE_ADDR = 32'h0,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    dbus_mem_responder_if.slave bus
);
    localparam int WC_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [WC_W-1:0]  WC_MAX   = WC_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [31:0]          mem [2**ADDR_BITS];
    logic [7:0]           fifo_mem [FIFO_DEPTH];
    logic [WC_W-1:0]      wc;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;

    logic                 req;
    logic                 is_console;
    logic                 con_write;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 console_stall;
    logic                 stall;
    logic                 done;
    logic                 push;
    logic                 pop;
    logic                 tx_valid;
    logic [ADDR_BITS-1:0] idx;
    logic [3:0]           lane_en;
    logic [31:0]          lane_data;

    // Byte-lane mask for a size code at a given byte offset; unknown codes write nothing.
    function automatic logic [3:0] lane_mask(input logic [3:0] size, input logic [1:0] off);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            4'h1: m = 4'b0001 << off;
            4'h3: m = off[1] ? 4'b1100 : 4'b0011;
            4'hF: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Right-aligned write data replicated so every lane sees its source bits.
    function automatic logic [31:0] lane_replicate(input logic [3:0] size, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        case (size)
            4'h1: r = {4{d[7:0]}};
            4'h3: r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    assign req        = bus.iDbusWe | bus.iDbusRead;
    assign is_console = (bus.iDbusAddr == CONSOLE_ADDR);
    assign con_write  = bus.iDbusWe & is_console & bus.iDbusByteEn[0];
    assign idx        = bus.iDbusAddr[ADDR_BITS+1:2];
    assign fifo_full  = (count == CNT_FULL);
    assign fifo_empty = (count == '0);
    assign tx_valid   = ~rst & ~fifo_empty;
    assign pop        = tx_valid & bus.iTxReady;
    // A pop in the same cycle frees the slot, so a full FIFO only stalls without one.
    assign console_stall = con_write & fifo_full & ~pop;
    assign stall      = rst | (req & ((wc != WC_MAX) | console_stall));
    assign done       = req & ~stall;
    assign push       = con_write & done;
    assign lane_en    = (done & bus.iDbusWe & ~is_console)
                        ? lane_mask(bus.iDbusByteEn, bus.iDbusAddr[1:0]) : 4'b0000;
    assign lane_data  = lane_replicate(bus.iDbusByteEn, bus.iDbusData);

    assign bus.oDbusWait = stall;
    assign bus.oTxValid  = tx_valid;
    assign bus.oTxData   = fifo_mem[rd_ptr];

    // Read data is presented only in the completion cycle of a pure read.
    always_comb begin
        bus.oDbusData = 32'h0;
        if (done & ~bus.iDbusWe & bus.iDbusRead) begin
            if (is_console) begin
                bus.oDbusData = {30'b0, fifo_full, fifo_empty};
            end else begin
                bus.oDbusData = mem[idx];
            end
        end
    end

    // Wait-state counter: climbs while stalled, clears on completion or dropped request.
    always_ff @(posedge clk) begin
        if (rst) begin
            wc <= '0;
        end else if (!req || done) begin
            wc <= '0;
        end else if (wc != WC_MAX) begin
            wc <= wc + 1'b1;
        end
    end

    // RAM lane writes commit only at the completion edge; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
                mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

    // Console FIFO storage; data is not reset, only the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.iDbusData[7:0];
        end
    end

    // Console FIFO pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_dbus_mem_responder.sv
// Directed bench for dbus_mem_responder: a zero-wait instance covers RAM
// lanes, aliasing and the console FIFO; a two-wait instance covers
// wait-state timing, aborted requests and reset during an access.
module tb_dbus_mem_responder;
    localparam logic [31:0] CON = 32'hFFFF_FFF0;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    dbus_mem_responder_if bus0 ();
    dbus_mem_responder_if bus2 ();

    dbus_mem_responder #(
        .ADDR_BITS(8), .WAIT_CYCLES(0), .CONSOLE_ADDR(CON), .FIFO_DEPTH(4)
    ) u0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    dbus_mem_responder #(
        .ADDR_BITS(8), .WAIT_CYCLES(2), .CONSOLE_ADDR(CON), .FIFO_DEPTH(4)
    ) u2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req0(input logic [31:0] a, input logic we, input logic rd,
                        input logic [3:0] be, input logic [31:0] d);
        bus0.iDbusAddr   = a;
        bus0.iDbusWe     = we;
        bus0.iDbusRead   = rd;
        bus0.iDbusByteEn = be;
        bus0.iDbusData   = d;
    endtask

    task automatic req2(input logic [31:0] a, input logic we, input logic rd,
                        input logic [3:0] be, input logic [31:0] d);
        bus2.iDbusAddr   = a;
        bus2.iDbusWe     = we;
        bus2.iDbusRead   = rd;
        bus2.iDbusByteEn = be;
        bus2.iDbusData   = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        req0(32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        req2(32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        bus0.iTxReady = 1'b0;
        bus2.iTxReady = 1'b0;
        tick();
        tick();

        // Reset state
        mid();
        chk("rst_wait0", 32'(bus0.oDbusWait), 32'd1);
        chk("rst_data0", bus0.oDbusData, 32'h0);
        chk("rst_txv0", 32'(bus0.oTxValid), 32'd0);
        chk("rst_wait2", 32'(bus2.oDbusWait), 32'd1);
        tick();
        rst = 1'b0;

        // Zero-wait word write and read
        req0(32'h10, 1'b1, 1'b0, 4'hF, 32'hDEADBEEF);
        mid();
        chk("w0_wait", 32'(bus0.oDbusWait), 32'd0);
        chk("w0_data", bus0.oDbusData, 32'h0);
        tick();
        req0(32'h10, 1'b0, 1'b1, 4'hF, 32'h0);
        mid();
        chk("r0_wait", 32'(bus0.oDbusWait), 32'd0);
        chk("r0_data", bus0.oDbusData, 32'hDEADBEEF);
        tick();

        // Byte then half lanes over a cleared word
        req0(32'h10, 1'b1, 1'b0, 4'hF, 32'h0);
        tick();
        req0(32'h13, 1'b1, 1'b0, 4'h1, 32'h000000AA);
        tick();
        req0(32'h10, 1'b0, 1'b1, 4'hF, 32'h0);
        mid();
        chk("byte_lane3", bus0.oDbusData, 32'hAA000000);
        tick();
        req0(32'h12, 1'b1, 1'b0, 4'h3, 32'h00001234);
        tick();
        req0(32'h10, 1'b0, 1'b1, 4'hF, 32'h0);
        mid();
        chk("half_upper", bus0.oDbusData, 32'h12340000);
        tick();

        // Out-of-range address aliases word 4
        req0(32'h410, 1'b1, 1'b0, 4'hF, 32'h55667788);
        tick();
        req0(32'h10, 1'b0, 1'b1, 4'hF, 32'h0);
        mid();
        chk("alias_410", bus0.oDbusData, 32'h55667788);
        tick();

        // Write and read together: write wins, no read data
        req0(32'h10, 1'b1, 1'b1, 4'hF, 32'hCAFEF00D);
        mid();
        chk("we_rd_wait", 32'(bus0.oDbusWait), 32'd0);
        chk("we_rd_data", bus0.oDbusData, 32'h0);
        tick();
        req0(32'h10, 1'b0, 1'b1, 4'hF, 32'h0);
        mid();
        chk("we_rd_commit", bus0.oDbusData, 32'hCAFEF00D);
        tick();

        // Unknown size code completes without a write
        req0(32'h10, 1'b1, 1'b0, 4'h2, 32'h0);
        mid();
        chk("badsize_wait", 32'(bus0.oDbusWait), 32'd0);
        tick();
        req0(32'h10, 1'b0, 1'b1, 4'hF, 32'h0);
        mid();
        chk("badsize_nochg", bus0.oDbusData, 32'hCAFEF00D);
        tick();

        // Half at odd offset lands in the low half
        req0(32'h11, 1'b1, 1'b0, 4'h3, 32'h0000BEEF);
        tick();
        req0(32'h10, 1'b0, 1'b1, 4'hF, 32'h0);
        mid();
        chk("half_lower", bus0.oDbusData, 32'hCAFEBEEF);
        tick();

        // Console: four bytes fill the FIFO, the fifth stalls
        req0(32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        mid();
        chk("con_empty_v", 32'(bus0.oTxValid), 32'd0);
        tick();
        req0(CON, 1'b1, 1'b0, 4'h1, 32'h48);
        mid();
        chk("con_H_wait", 32'(bus0.oDbusWait), 32'd0);
        tick();
        req0(CON, 1'b1, 1'b0, 4'h1, 32'h69);
        tick();
        req0(CON, 1'b1, 1'b0, 4'h1, 32'h21);
        tick();
        req0(CON, 1'b1, 1'b0, 4'h1, 32'h78);
        mid();
        chk("con_x_wait", 32'(bus0.oDbusWait), 32'd0);
        tick();
        req0(CON, 1'b0, 1'b1, 4'hF, 32'h0);
        mid();
        chk("con_stat_full", bus0.oDbusData, 32'h2);
        chk("con_head_H", 32'(bus0.oTxData), 32'h48);
        chk("con_valid", 32'(bus0.oTxValid), 32'd1);
        tick();
        req0(CON, 1'b1, 1'b0, 4'h1, 32'h79);
        mid();
        chk("con_y_stall1", 32'(bus0.oDbusWait), 32'd1);
        tick();
        mid();
        chk("con_y_stall2", 32'(bus0.oDbusWait), 32'd1);
        bus0.iTxReady = 1'b1;
        #1;
        chk("con_y_go", 32'(bus0.oDbusWait), 32'd0);
        chk("con_pop_H", 32'(bus0.oTxData), 32'h48);
        tick();
        req0(32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        mid();
        chk("con_pop_i", 32'(bus0.oTxData), 32'h69);
        tick();
        mid();
        chk("con_pop_bang", 32'(bus0.oTxData), 32'h21);
        tick();
        mid();
        chk("con_pop_x", 32'(bus0.oTxData), 32'h78);
        tick();
        mid();
        chk("con_pop_y", 32'(bus0.oTxData), 32'h79);
        chk("con_pop_y_v", 32'(bus0.oTxValid), 32'd1);
        tick();
        bus0.iTxReady = 1'b0;
        req0(CON, 1'b0, 1'b1, 4'hF, 32'h0);
        mid();
        chk("con_drained_v", 32'(bus0.oTxValid), 32'd0);
        chk("con_stat_empty", bus0.oDbusData, 32'h1);
        tick();

        // Two wait states: write then read take three cycles each
        req0(32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        req2(32'h20, 1'b1, 1'b0, 4'hF, 32'h11223344);
        mid();
        chk("w2_wait_c1", 32'(bus2.oDbusWait), 32'd1);
        tick();
        mid();
        chk("w2_wait_c2", 32'(bus2.oDbusWait), 32'd1);
        tick();
        mid();
        chk("w2_done_c3", 32'(bus2.oDbusWait), 32'd0);
        tick();
        req2(32'h20, 1'b0, 1'b1, 4'hF, 32'h0);
        mid();
        chk("r2_wait_c1", 32'(bus2.oDbusWait), 32'd1);
        chk("r2_data_c1", bus2.oDbusData, 32'h0);
        tick();
        mid();
        chk("r2_wait_c2", 32'(bus2.oDbusWait), 32'd1);
        chk("r2_data_c2", bus2.oDbusData, 32'h0);
        tick();
        mid();
        chk("r2_wait_c3", 32'(bus2.oDbusWait), 32'd0);
        chk("r2_data_c3", bus2.oDbusData, 32'h11223344);
        tick();

        // Aborted write after one wait leaves memory alone
        req2(32'h20, 1'b1, 1'b0, 4'hF, 32'h99999999);
        mid();
        chk("abort_wait", 32'(bus2.oDbusWait), 32'd1);
        tick();
        req2(32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        tick();
        req2(32'h20, 1'b0, 1'b1, 4'hF, 32'h0);
        mid();
        chk("abort_rd_c1", 32'(bus2.oDbusWait), 32'd1);
        tick();
        mid();
        chk("abort_rd_c2", 32'(bus2.oDbusWait), 32'd1);
        tick();
        mid();
        chk("abort_rd_data", bus2.oDbusData, 32'h11223344);
        tick();

        // Reset during a waited write, with a byte pending in the console FIFO
        req0(CON, 1'b1, 1'b0, 4'h1, 32'h5A);
        req2(32'h20, 1'b1, 1'b0, 4'hF, 32'hAAAAAAAA);
        tick();
        req0(32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        mid();
        chk("pre_rst_txv", 32'(bus0.oTxValid), 32'd1);
        chk("pre_rst_head", 32'(bus0.oTxData), 32'h5A);
        tick();
        rst = 1'b1;
        mid();
        chk("mid_rst_wait", 32'(bus2.oDbusWait), 32'd1);
        chk("mid_rst_data", bus2.oDbusData, 32'h0);
        chk("mid_rst_txv", 32'(bus0.oTxValid), 32'd0);
        tick();
        mid();
        chk("mid_rst_wait_b", 32'(bus2.oDbusWait), 32'd1);
        tick();
        rst = 1'b0;
        req2(32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        mid();
        chk("post_rst_txv", 32'(bus0.oTxValid), 32'd0);
        tick();
        req2(32'h20, 1'b0, 1'b1, 4'hF, 32'h0);
        mid();
        chk("post_rst_c1", 32'(bus2.oDbusWait), 32'd1);
        tick();
        mid();
        chk("post_rst_c2", 32'(bus2.oDbusWait), 32'd1);
        tick();
        mid();
        chk("post_rst_c3", 32'(bus2.oDbusWait), 32'd0);
        chk("post_rst_data", bus2.oDbusData, 32'h11223344);
        tick();
        req2(32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
